// File: rtl/led_pwm_bank.sv
`default_nettype none
// ============================================================================
//  Module   : led_pwm_bank
//  Purpose  : Bank of CH LED drivers, each OFF / ON / PWM / blinking PWM,
//             sharing one PWM counter and one blink time-base prescaler.
//  Revision : 1.0  initial release
// ============================================================================
module led_pwm_bank #(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int CH       = 4,
  parameter int PWM_BITS = 8,
  parameter int DEF_HALF = 500
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iWE,
  input  logic [3:0]          iCH,
  input  logic [1:0]          iMODE,
  input  logic [PWM_BITS-1:0] iDUTY,
  input  logic [15:0]         iHALF,
  output logic [CH-1:0]       oLED,
  output logic                oTICK,
  output logic                oACK
);

  localparam int c_DIV_RAW = CLK_HZ / TICK_HZ;
  localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
  localparam int c_PW      = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(c_DIV - 1);

  localparam logic [1:0] c_MODE_OFF   = 2'b00;
  localparam logic [1:0] c_MODE_ON    = 2'b01;
  localparam logic [1:0] c_MODE_PWM   = 2'b10;
  localparam logic [1:0] c_MODE_BLINK = 2'b11;

  logic [c_PW-1:0]     r_preCnt;
  logic                r_tick;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic                r_ack;
  logic [CH-1:0]       r_led;
  logic [CH-1:0]       w_ledNext;
  logic                w_wrOk;

  assign w_wrOk = iWE && ({1'b0, iCH} < 5'(CH));

  // r_tick is high in the cycle after the prescaler wraps; blink advances on it
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_preCnt <= '0;
      r_tick   <= 1'b0;
    end else if (r_preCnt == c_PRE_LAST) begin
      r_preCnt <= '0;
      r_tick   <= 1'b1;
    end else begin
      r_preCnt <= r_preCnt + 1'b1;
      r_tick   <= 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pwmCnt <= '0;
      r_ack    <= 1'b0;
      r_led    <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + 1'b1;
      r_ack    <= w_wrOk;
      r_led    <= w_ledNext;
    end
  end

  generate
    for (genvar n = 0; n < CH; n++) begin : g_ch
      logic [1:0]          r_mode;
      logic [PWM_BITS-1:0] r_duty;
      logic [15:0]         r_half;
      logic [15:0]         r_cnt;
      logic                r_phase;
      logic                w_sel;
      logic                w_pwmOn;
      logic [15:0]         w_halfLast;

      assign w_sel      = w_wrOk && (iCH == 4'(n));
      assign w_pwmOn    = (r_pwmCnt < r_duty);
      assign w_halfLast = (r_half == 16'd0) ? 16'd0 : r_half - 16'd1;

      // a write on a tick cycle wins, so the load branch comes first
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          r_mode  <= c_MODE_OFF;
          r_duty  <= '0;
          r_half  <= 16'(DEF_HALF);
          r_cnt   <= 16'd0;
          r_phase <= 1'b1;
        end else if (w_sel) begin
          r_mode  <= iMODE;
          r_duty  <= iDUTY;
          r_half  <= iHALF;
          r_cnt   <= 16'd0;
          r_phase <= 1'b1;
        end else if (r_tick && (r_mode == c_MODE_BLINK)) begin
          if (r_cnt >= w_halfLast) begin
            r_cnt   <= 16'd0;
            r_phase <= ~r_phase;
          end else begin
            r_cnt   <= r_cnt + 16'd1;
          end
        end
      end

      assign w_ledNext[n] = (r_mode == c_MODE_ON)
                          | ((r_mode == c_MODE_PWM)   & w_pwmOn)
                          | ((r_mode == c_MODE_BLINK) & r_phase & w_pwmOn);
    end
  endgenerate

  assign oLED  = r_led;
  assign oTICK = r_tick;
  assign oACK  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_led_pwm_bank
//  Purpose  : Randomized scoreboard bench for led_pwm_bank (DIV=12, 4 ch, 4-bit PWM).
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_pwm_bank;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iWE  = 1'b0;
  logic [3:0] iCH  = '0;
  logic [1:0] iMODE = '0;
  logic [3:0] iDUTY = '0;
  logic [15:0] iHALF = '0;
  logic [3:0] oLED;
  logic       oTICK;
  logic       oACK;

  led_pwm_bank #(
    .CLK_HZ(12000000), .TICK_HZ(1000000), .CH(4), .PWM_BITS(4), .DEF_HALF(500)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iWE(iWE), .iCH(iCH), .iMODE(iMODE),
    .iDUTY(iDUTY), .iHALF(iHALF), .oLED(oLED), .oTICK(oTICK), .oACK(oACK)
  );

  always #41.667 iCLK = ~iCLK;

  typedef struct {
    logic [3:0] led;
    logic       tick;
    logic       ack;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  // reference model: closed-form in terms of edges since reset release
  int t = 0;
  int mMode[4], mDuty[4], mHalf[4], mWr[4];

  function automatic int ticksUpTo(int x);
    return (x < 12) ? 0 : x / 12;
  endfunction

  function automatic logic ledModel(int n, int tt);
    int  p, h, nt;
    bit  on, ph;
    p  = (tt - 1) % 16;
    on = (p < mDuty[n]);
    h  = (mHalf[n] < 1) ? 1 : mHalf[n];
    // tick cycles strictly after the write edge and before edge tt
    nt = ticksUpTo(tt - 2) - ticksUpTo(mWr[n] - 1);
    ph = ((nt / h) % 2) == 0;
    case (mMode[n])
      0: return 1'b0;
      1: return 1'b1;
      2: return on;
      default: return ph && on;
    endcase
  endfunction

  task automatic modelReset();
    t = 0;
    for (int n = 0; n < 4; n++) begin
      mMode[n] = 0; mDuty[n] = 0; mHalf[n] = 500; mWr[n] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, req);
    end
  endtask

  // one clock: present inputs, predict the outcome of the coming edge
  task automatic cycle(input bit we, input int ch, input int mode, input int duty, input int half);
    exp_t e;
    iWE = we; iCH = 4'(ch); iMODE = 2'(mode); iDUTY = 4'(duty); iHALF = 16'(half);
    t++;
    e.tick = (t % 12 == 0);
    e.ack  = we && (ch < 4);
    for (int n = 0; n < 4; n++) e.led[n] = ledModel(n, t);
    @(posedge iCLK); #2;
    q.push_back(e);
    if (e.ack) begin
      mMode[ch] = mode; mDuty[ch] = duty; mHalf[ch] = half; mWr[ch] = t;
    end
  endtask

  task automatic idle();
    cycle(1'b0, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 15),
          $urandom_range(0, 65535));
  endtask

  always @(negedge iCLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!iRST) begin
        check("oLED",  int'(oLED),  int'(e.led));
        check("oTICK", int'(oTICK), int'(e.tick));
        check("oACK",  int'(oACK),  int'(e.ack));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    modelReset();
    repeat (3) @(posedge iCLK);
    #2;
    check("reset_oLED",  int'(oLED),  0);
    check("reset_oTICK", int'(oTICK), 0);
    check("reset_oACK",  int'(oACK),  0);
    iRST = 1'b0;

    repeat (1000) idle();

    cycle(1'b1, 0, 1, $urandom_range(0, 15), $urandom_range(0, 65535));
    cycle(1'b1, 1, 2, 4, $urandom_range(0, 65535));
    repeat (64) idle();

    cycle(1'b1, 2, 3, 15, 3);
    repeat (200) idle();

    cycle(1'b1, 7, 2, 0, 0);
    repeat (20) idle();
    cycle(1'b1, 3, 2, 0, 0);
    repeat (40) idle();

    // BLINK write landing on a tick cycle
    while (t % 12 != 0) idle();
    cycle(1'b1, 2, 3, 15, 3);
    repeat (150) idle();

    cycle(1'b1, 2, 3, 9, 2);
    cycle(1'b1, 2, 3, 9, 2);
    repeat (100) idle();

    // asynchronous reset mid-operation, with a write in flight
    cycle(1'b1, 0, 1, 0, 0);
    repeat (5) idle();
    iWE = 1'b1; iCH = 4'd1; iMODE = 2'd1; iDUTY = 4'd7; iHALF = 16'd1;
    #18;
    iRST = 1'b1;
    #1;
    check("async_rst_oLED",  int'(oLED),  0);
    check("async_rst_oTICK", int'(oTICK), 0);
    check("async_rst_oACK",  int'(oACK),  0);
    iWE = 1'b0;
    repeat (2) @(posedge iCLK);
    #2;
    q.delete();
    modelReset();
    iRST = 1'b0;
    repeat (100) idle();

    repeat (3000) begin
      if ($urandom_range(0, 15) == 0)
        cycle(1'b1, $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 15),
              $urandom_range(0, 4));
      else
        idle();
    end

    @(negedge iCLK);
    #1;
    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
